// File: rtl/wb_i2c_bfm_if_if.sv
// Bundle of every bus-facing signal of the Wishbone/I2C bench companion.
// The master modport is the companion's own view (it masters Wishbone and
// owns the slave side of I2C); the slave modport is the environment's view.
interface wb_i2c_bfm_if_if #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_DATA_WIDTH = 8
);
  // Request / response side
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_we_i;
  logic [WB_ADDR_WIDTH-1:0]  req_adr_i;
  logic [WB_DATA_WIDTH-1:0]  req_dat_i;
  logic                      rsp_valid_o;
  logic [WB_DATA_WIDTH-1:0]  rsp_dat_o;
  // Wishbone master bus
  logic                      cyc_o;
  logic                      stb_o;
  logic                      we_o;
  logic [WB_ADDR_WIDTH-1:0]  adr_o;
  logic [WB_DATA_WIDTH-1:0]  dat_o;
  logic [WB_DATA_WIDTH-1:0]  dat_i;
  logic                      ack_i;
  // Wishbone monitor
  logic                      mon_valid_o;
  logic [WB_ADDR_WIDTH-1:0]  mon_adr_o;
  logic [WB_DATA_WIDTH-1:0]  mon_dat_o;
  logic                      mon_we_o;
  // I2C bus and transfer reporting
  logic                      scl_i;
  logic                      sda_i;
  logic                      scl_o;
  logic                      sda_o;
  logic                      i2c_start_o;
  logic                      i2c_addr_valid_o;
  logic                      i2c_op_o;
  logic                      i2c_byte_valid_o;
  logic [I2C_DATA_WIDTH-1:0] i2c_byte_o;
  logic [I2C_DATA_WIDTH-1:0] i2c_rd_dat_i;
  logic                      i2c_stop_o;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_dat_i, dat_i, ack_i,
           scl_i, sda_i, i2c_rd_dat_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, cyc_o, stb_o, we_o, adr_o,
           dat_o, mon_valid_o, mon_adr_o, mon_dat_o, mon_we_o, scl_o, sda_o,
           i2c_start_o, i2c_addr_valid_o, i2c_op_o, i2c_byte_valid_o,
           i2c_byte_o, i2c_stop_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_dat_i, dat_i, ack_i,
           scl_i, sda_i, i2c_rd_dat_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, cyc_o, stb_o, we_o, adr_o,
           dat_o, mon_valid_o, mon_adr_o, mon_dat_o, mon_we_o, scl_o, sda_o,
           i2c_start_o, i2c_addr_valid_o, i2c_op_o, i2c_byte_valid_o,
           i2c_byte_o, i2c_stop_o
  );
endinterface

// File: rtl/wb_i2c_bfm_if.sv
// Bench-side companion for the I2C multi-bus controller: a single-request
// Wishbone master with a cycle monitor, and an independent I2C slave that
// ACKs its own address and write bytes and serves read bytes.
module wb_i2c_bfm_if #(
  parameter int                      WB_ADDR_WIDTH  = 2,
  parameter int                      WB_DATA_WIDTH  = 8,
  parameter int                      I2C_ADDR_WIDTH = 7,
  parameter int                      I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR   = 7'h22
) (
  input logic               clk_i,
  input logic               rst_ni,
  wb_i2c_bfm_if_if.master   bus
);

  // ---------------------------------------------------------------------
  // Wishbone master
  // ---------------------------------------------------------------------
  typedef enum logic {WB_IDLE, WB_BUS} wb_state_e;

  wb_state_e                r_wb_state;
  logic                     r_req_ready;
  logic                     r_rsp_valid;
  logic [WB_DATA_WIDTH-1:0] r_rsp_dat;
  logic                     r_cyc;
  logic                     r_stb;
  logic                     r_we;
  logic [WB_ADDR_WIDTH-1:0] r_adr;
  logic [WB_DATA_WIDTH-1:0] r_dat;
  logic                     r_mon_valid;
  logic [WB_ADDR_WIDTH-1:0] r_mon_adr;
  logic [WB_DATA_WIDTH-1:0] r_mon_dat;
  logic                     r_mon_we;

  // Request accept, hold the cycle until ack, then report and re-arm.
  // Ready is re-raised one cycle after returning to IDLE, so back-to-back
  // requests with an immediate ack run at one every three cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_state  <= WB_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_mon_valid <= 1'b0;
      r_mon_adr   <= '0;
      r_mon_dat   <= '0;
      r_mon_we    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register in this block
      // samples pre-edge values regardless of statement order.
      r_rsp_valid <= 1'b0;
      r_mon_valid <= 1'b0;
      case (r_wb_state)
        WB_IDLE: begin
          if (r_req_ready && bus.req_valid_i) begin
            r_req_ready <= 1'b0;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_we        <= bus.req_we_i;
            r_adr       <= bus.req_adr_i;
            r_dat       <= bus.req_dat_i;
            r_wb_state  <= WB_BUS;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WB_BUS: begin
          if (bus.ack_i) begin
            r_rsp_dat   <= bus.dat_i;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_mon_valid <= 1'b1;
            r_mon_adr   <= r_adr;
            r_mon_we    <= r_we;
            r_mon_dat   <= r_we ? r_dat : bus.dat_i;
            r_wb_state  <= WB_IDLE;
          end
        end
        default: r_wb_state <= WB_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_dat_o   = r_rsp_dat;
  assign bus.cyc_o       = r_cyc;
  assign bus.stb_o       = r_stb;
  assign bus.we_o        = r_we;
  assign bus.adr_o       = r_adr;
  assign bus.dat_o       = r_dat;
  assign bus.mon_valid_o = r_mon_valid;
  assign bus.mon_adr_o   = r_mon_adr;
  assign bus.mon_dat_o   = r_mon_dat;
  assign bus.mon_we_o    = r_mon_we;

  // ---------------------------------------------------------------------
  // I2C input conditioning
  // ---------------------------------------------------------------------
  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;

  // Two-flop synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: reset to the idle-bus level (both lines high) so releasing
      // reset can never fabricate a START or STOP edge.
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.scl_i};
      r_sda_sync <= {r_sda_sync[0], bus.sda_i};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  // ---------------------------------------------------------------------
  // I2C slave FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    I2C_IDLE, I2C_ADDR, I2C_ADDR_ACK, I2C_WR_DATA, I2C_WR_ACK,
    I2C_RD_DATA, I2C_RD_ACK
  } i2c_state_e;

  localparam int                CNT_W    = $clog2(I2C_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(I2C_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  ALL_BITS = CNT_W'(I2C_DATA_WIDTH);

  i2c_state_e                r_i2c_state;
  logic [CNT_W-1:0]          r_bit_cnt;
  logic [I2C_DATA_WIDTH-1:0] r_shift;
  logic                      r_ack_phase;
  logic                      r_sda_o;
  logic                      r_start;
  logic                      r_addr_valid;
  logic                      r_op;
  logic                      r_byte_valid;
  logic [I2C_DATA_WIDTH-1:0] r_byte;
  logic                      r_stop;

  logic [I2C_DATA_WIDTH-1:0] w_shift_next;
  assign w_shift_next = {r_shift[I2C_DATA_WIDTH-2:0], w_sda};

  // Bus conditions first (START/STOP override everything), then per-state
  // bit shifting, ACK driving and read-byte serialisation. The ACK state
  // uses r_ack_phase: phase 0 waits for the fall that starts the ACK bit,
  // phase 1 waits for the fall that ends it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_i2c_state  <= I2C_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_ack_phase  <= 1'b0;
      r_sda_o      <= 1'b1;
      r_start      <= 1'b0;
      r_addr_valid <= 1'b0;
      r_op         <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_stop       <= 1'b0;
    end else begin
      r_start      <= 1'b0;
      r_addr_valid <= 1'b0;
      r_byte_valid <= 1'b0;
      r_stop       <= 1'b0;
      if (w_start) begin
        r_start     <= 1'b1;
        r_sda_o     <= 1'b1;
        r_bit_cnt   <= '0;
        r_ack_phase <= 1'b0;
        r_i2c_state <= I2C_ADDR;
      end else if (w_stop) begin
        r_stop      <= 1'b1;
        r_sda_o     <= 1'b1;
        r_i2c_state <= I2C_IDLE;
      end else begin
        case (r_i2c_state)
          I2C_IDLE: ;
          I2C_ADDR, I2C_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt   <= '0;
                r_ack_phase <= 1'b0;
                if (r_i2c_state == I2C_ADDR) begin
                  if (w_shift_next[I2C_DATA_WIDTH-1:1] == SLAVE_ADDR) begin
                    r_addr_valid <= 1'b1;
                    r_op         <= w_shift_next[0];
                    r_i2c_state  <= I2C_ADDR_ACK;
                  end else begin
                    r_i2c_state  <= I2C_IDLE;
                  end
                end else begin
                  r_byte_valid <= 1'b1;
                  r_byte       <= w_shift_next;
                  r_i2c_state  <= I2C_WR_ACK;
                end
              end
            end
          end
          I2C_ADDR_ACK, I2C_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_o     <= 1'b0;
                r_ack_phase <= 1'b1;
              end else begin
                r_ack_phase <= 1'b0;
                r_bit_cnt   <= '0;
                if (r_i2c_state == I2C_ADDR_ACK && r_op) begin
                  r_shift     <= bus.i2c_rd_dat_i;
                  r_sda_o     <= bus.i2c_rd_dat_i[I2C_DATA_WIDTH-1];
                  r_i2c_state <= I2C_RD_DATA;
                end else begin
                  r_sda_o     <= 1'b1;
                  r_i2c_state <= I2C_WR_DATA;
                end
              end
            end
          end
          I2C_RD_DATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end else if (w_scl_fall) begin
              if (r_bit_cnt == ALL_BITS) begin
                r_sda_o     <= 1'b1;
                r_ack_phase <= 1'b0;
                r_i2c_state <= I2C_RD_ACK;
              end else begin
                r_sda_o <= r_shift[I2C_DATA_WIDTH-2];
                r_shift <= {r_shift[I2C_DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          I2C_RD_ACK: begin
            if (!r_ack_phase) begin
              if (w_scl_rise) begin
                if (w_sda) r_i2c_state <= I2C_IDLE;
                else       r_ack_phase <= 1'b1;
              end
            end else if (w_scl_fall) begin
              r_ack_phase <= 1'b0;
              r_bit_cnt   <= '0;
              r_shift     <= bus.i2c_rd_dat_i;
              r_sda_o     <= bus.i2c_rd_dat_i[I2C_DATA_WIDTH-1];
              r_i2c_state <= I2C_RD_DATA;
            end
          end
          default: r_i2c_state <= I2C_IDLE;
        endcase
      end
    end
  end

  assign bus.scl_o            = 1'b1;
  assign bus.sda_o            = r_sda_o;
  assign bus.i2c_start_o      = r_start;
  assign bus.i2c_addr_valid_o = r_addr_valid;
  assign bus.i2c_op_o         = r_op;
  assign bus.i2c_byte_valid_o = r_byte_valid;
  assign bus.i2c_byte_o       = r_byte;
  assign bus.i2c_stop_o       = r_stop;

endmodule

// File: tb/tb_wb_i2c_bfm_if.sv
// Directed bench for wb_i2c_bfm_if: a table of Wishbone requests with
// hand-computed results, plus hand-written I2C and reset sequences.
module tb_wb_i2c_bfm_if;

  localparam int Q = 6; // clk cycles per quarter of an I2C bit

  logic clk;
  logic rst_n;
  logic r_scl_m;
  logic r_sda_m;
  int   n_total;
  int   n_pass;

  wb_i2c_bfm_if_if bus ();

  wb_i2c_bfm_if dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  // Open-drain wiring: bus level is the AND of master and slave drivers.
  logic w_bus_sda;
  assign w_bus_sda  = r_sda_m & bus.sda_o;
  assign bus.scl_i  = r_scl_m & bus.scl_o;
  assign bus.sda_i  = w_bus_sda;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors, sampled on the inactive edge.
  int         n_start, n_addr, n_byte, n_stop, n_sda_low;
  logic       last_op;
  logic [7:0] last_byte;
  initial begin
    n_start = 0; n_addr = 0; n_byte = 0; n_stop = 0; n_sda_low = 0;
    last_op = 1'b0; last_byte = 8'h00;
  end
  always @(negedge clk) begin
    if (bus.i2c_start_o) n_start++;
    if (bus.i2c_addr_valid_o) begin n_addr++; last_op = bus.i2c_op_o; end
    if (bus.i2c_byte_valid_o) begin n_byte++; last_byte = bus.i2c_byte_o; end
    if (bus.i2c_stop_o) n_stop++;
    if (!bus.sda_o) n_sda_low++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
    int         delay;       // extra cycles before ack is presented
    logic [7:0] rd;          // dat_i returned with ack
    int         exp_cyc;     // cycles with cyc_o & stb_o high
    logic [7:0] exp_rsp;
    logic [7:0] exp_mon_dat;
  } wb_vec_t;

  wb_vec_t vecs [4];

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic wb_xfer(input wb_vec_t v, input string tag);
    int n;
    int cyc_cnt;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready_o) begin
      check({tag, " ready timeout"}, 32'(bus.req_ready_o), 32'd1);
      return;
    end
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = v.we;
    bus.req_adr_i   = v.adr;
    bus.req_dat_i   = v.dat;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_dat_i   = 8'h00;
    cyc_cnt = 0;
    for (int k = 0; k <= v.delay; k++) begin
      if (bus.cyc_o && bus.stb_o) cyc_cnt++;
      if (k == 0) begin
        check({tag, " bus adr/dat/we"}, {22'd0, bus.adr_o, bus.dat_o, bus.we_o},
              {22'd0, v.adr, v.dat, v.we});
        check({tag, " ready low in BUS"}, 32'(bus.req_ready_o), 32'd0);
      end
      if (k == v.delay) begin bus.ack_i = 1'b1; bus.dat_i = v.rd; end
      @(negedge clk);
    end
    bus.ack_i = 1'b0;
    bus.dat_i = 8'hEE;
    check({tag, " cyc cycles"}, 32'(cyc_cnt), 32'(v.exp_cyc));
    check({tag, " cyc/stb/we drop"}, {29'd0, bus.cyc_o, bus.stb_o, bus.we_o}, 32'd0);
    check({tag, " rsp/mon valid"}, {30'd0, bus.rsp_valid_o, bus.mon_valid_o}, 32'd3);
    check({tag, " rsp_dat"}, 32'(bus.rsp_dat_o), 32'(v.exp_rsp));
    check({tag, " mon adr/dat/we"}, {21'd0, bus.mon_adr_o, bus.mon_dat_o, bus.mon_we_o},
          {21'd0, v.adr, v.exp_mon_dat, v.we});
    check({tag, " ready low after ack"}, 32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    check({tag, " pulse end/ready/rsp hold"},
          {22'd0, bus.rsp_valid_o, bus.mon_valid_o, bus.req_ready_o, bus.rsp_dat_o},
          {22'd0, 1'b0, 1'b0, 1'b1, v.exp_rsp});
  endtask

  task automatic i2c_start();
    r_sda_m = 1'b1; r_scl_m = 1'b1; wait_q();
    r_sda_m = 1'b0; wait_q();
    r_scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    r_sda_m = 1'b0; wait_q();
    r_scl_m = 1'b1; wait_q();
    r_sda_m = 1'b1; wait_q(); wait_q();
  endtask

  task automatic send_bit(input logic b);
    r_sda_m = b; wait_q();
    r_scl_m = 1'b1; wait_q(); wait_q();
    r_scl_m = 1'b0; wait_q();
  endtask

  // Eight data bits then the ACK clock; ack returns the sampled bus level.
  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    r_sda_m = 1'b1; wait_q();
    r_scl_m = 1'b1; wait_q();
    ack = w_bus_sda; wait_q();
    r_scl_m = 1'b0; wait_q();
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nak);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r_sda_m = 1'b1; wait_q();
      r_scl_m = 1'b1; wait_q();
      b = {b[6:0], w_bus_sda}; wait_q();
      r_scl_m = 1'b0; wait_q();
    end
    send_bit(nak);
    r_sda_m = 1'b1;
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    logic [7:0] rb2;
    int         s_start, s_addr, s_byte, s_stop, s_low;

    n_total = 0; n_pass = 0;
    rst_n = 1'b0; r_scl_m = 1'b1; r_sda_m = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_adr_i = '0;
    bus.req_dat_i = '0; bus.dat_i = '0; bus.ack_i = 1'b0;
    bus.i2c_rd_dat_i = '0;

    vecs[0] = '{we: 1'b1, adr: 2'h1, dat: 8'h05, delay: 2, rd: 8'h11,
                exp_cyc: 3, exp_rsp: 8'h11, exp_mon_dat: 8'h05};
    vecs[1] = '{we: 1'b0, adr: 2'h2, dat: 8'h00, delay: 0, rd: 8'h80,
                exp_cyc: 1, exp_rsp: 8'h80, exp_mon_dat: 8'h80};
    vecs[2] = '{we: 1'b0, adr: 2'h3, dat: 8'hAA, delay: 1, rd: 8'h3C,
                exp_cyc: 2, exp_rsp: 8'h3C, exp_mon_dat: 8'h3C};
    vecs[3] = '{we: 1'b1, adr: 2'h0, dat: 8'hFF, delay: 0, rd: 8'h00,
                exp_cyc: 1, exp_rsp: 8'h00, exp_mon_dat: 8'hFF};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset wb req/rsp", {22'd0, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_dat_o}, 32'd0);
    check("reset wb bus", {20'd0, bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o}, 32'd0);
    check("reset wb mon", {20'd0, bus.mon_valid_o, bus.mon_adr_o, bus.mon_dat_o, bus.mon_we_o}, 32'd0);
    check("reset scl_o/sda_o", {30'd0, bus.scl_o, bus.sda_o}, 32'd3);
    check("reset i2c pulses", {19'd0, bus.i2c_start_o, bus.i2c_addr_valid_o, bus.i2c_op_o,
          bus.i2c_byte_valid_o, bus.i2c_byte_o, bus.i2c_stop_o}, 32'd0);
    rst_n = 1'b1;

    // Wishbone request table
    for (int i = 0; i < 4; i++) wb_xfer(vecs[i], $sformatf("wb%0d", i));

    // I2C write: START 0x44 0x78 STOP
    s_start = n_start; s_addr = n_addr; s_byte = n_byte; s_stop = n_stop;
    i2c_start();
    write_byte(8'h44, ack);
    check("i2c wr addr ack", 32'(ack), 32'd0);
    check("i2c wr addr_valid op", {31'd0, last_op}, 32'd0);
    write_byte(8'h78, ack);
    check("i2c wr data ack", 32'(ack), 32'd0);
    check("i2c wr byte", 32'(last_byte), 32'h78);
    i2c_stop();
    check("i2c wr pulse counts", {n_start - s_start, n_addr - s_addr, n_byte - s_byte,
          n_stop - s_stop} == {32'd1, 32'd1, 32'd1, 32'd1} ? 32'd1 : 32'd0, 32'd1);
    check("i2c wr sda released", 32'(bus.sda_o), 32'd1);

    // I2C address mismatch: 0x46
    s_addr = n_addr; s_low = n_sda_low;
    i2c_start();
    write_byte(8'h46, ack);
    check("i2c mismatch no ack", 32'(ack), 32'd1);
    write_byte(8'h44, ack);
    check("i2c mismatch stays idle", 32'(ack), 32'd1);
    i2c_stop();
    check("i2c mismatch no addr_valid", 32'(n_addr - s_addr), 32'd0);
    check("i2c mismatch sda never low", 32'(n_sda_low - s_low), 32'd0);

    // I2C read of A5 with NAK
    bus.i2c_rd_dat_i = 8'hA5;
    i2c_start();
    write_byte(8'h45, ack);
    check("i2c rd addr ack", 32'(ack), 32'd0);
    check("i2c rd op", {31'd0, last_op}, 32'd1);
    bus.i2c_rd_dat_i = 8'h5A;
    read_byte(rb, 1'b1);
    check("i2c rd byte A5", 32'(rb), 32'hA5);
    check("i2c rd sda released", 32'(bus.sda_o), 32'd1);
    read_byte(rb, 1'b1);
    check("i2c rd idle after nak", 32'(rb), 32'hFF);
    i2c_stop();

    // I2C read of two bytes: ACK then NAK
    bus.i2c_rd_dat_i = 8'h3C;
    i2c_start();
    write_byte(8'h45, ack);
    bus.i2c_rd_dat_i = 8'hC3;
    read_byte(rb, 1'b0);
    read_byte(rb2, 1'b1);
    check("i2c rd2 bytes", {16'd0, rb, rb2}, 32'h3CC3);
    i2c_stop();

    // Reset during a Wishbone cycle and an address ACK
    @(negedge clk);
    while (!bus.req_ready_o) @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1;
    bus.req_adr_i = 2'h2; bus.req_dat_i = 8'h5A;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h44 >> i));
    check("pre-reset cyc/sda", {30'd0, bus.cyc_o, bus.sda_o}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("async reset cyc/stb/sda", {29'd0, bus.cyc_o, bus.stb_o, bus.sda_o}, 32'd1);
    r_scl_m = 1'b1; r_sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(vecs[1], "post-reset wb");
    i2c_start();
    write_byte(8'h44, ack);
    check("post-reset i2c ack", 32'(ack), 32'd0);
    i2c_stop();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
